// File: rtl/window_3x3_linebuf.sv
// window_3x3_linebuf
// ------------------
// Streaming 3x3 sliding-window generator for raster-order pixel streams.
// Two internal line buffers hold the previous two rows. Each accepted pixel
// shifts a new column into a registered 3x3 window. t_out flags the windows
// that lie completely inside the current frame.
//
// Optional feature macro: LINEBUF_FRAME_DONE_EN
//   When defined, the frame_done output is added. It pulses for one cycle
//   after the last pixel of a frame is accepted.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   t          pixel-valid strobe; in_data is accepted when t=1
//   in_data    pixel in raster order (row-major, column 0 first)
//   win_data   window [row][col]; [0][*] is the oldest row, [*][2] the newest column
//   frame_done (LINEBUF_FRAME_DONE_EN only) end-of-frame pulse
//   t_out      one-cycle pulse: win_data holds a complete in-image window
module window_3x3_linebuf #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int IMG_WIDTH     = 16,
  parameter int IMG_HEIGHT    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     t,
  input  logic [ELEMENT_WIDTH-1:0] in_data,
  output logic [ELEMENT_WIDTH-1:0] win_data [3][3],
`ifdef LINEBUF_FRAME_DONE_EN
  output logic                     frame_done,
`endif
  output logic                     t_out
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]            colCnt_q, colCnt_d;
  logic [RW-1:0]            rowCnt_q, rowCnt_d;
  logic [ELEMENT_WIDTH-1:0] lb0_q [IMG_WIDTH];
  logic [ELEMENT_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [ELEMENT_WIDTH-1:0] win_q [3][3];
  logic [ELEMENT_WIDTH-1:0] win_d [3][3];
  logic [ELEMENT_WIDTH-1:0] newCol [3];
  logic                     tOut_q, tOut_d;
  logic                     colLast, rowLast;

  assign colLast = (colCnt_q == COL_LAST);
  assign rowLast = (rowCnt_q == ROW_LAST);

  // Next-state logic. The new column is read from both line buffers at the
  // current column before they are written, so row r-2 comes from lb0 and row
  // r-1 comes from lb1. The window only moves on accepted pixels. t_out is
  // raised only when the three columns and three rows all belong to the
  // current frame: at least two earlier rows and two earlier columns.
  always_comb begin
    colCnt_d  = colCnt_q;
    rowCnt_d  = rowCnt_q;
    win_d     = win_q;
    tOut_d    = 1'b0;
    newCol[0] = lb0_q[colCnt_q];
    newCol[1] = lb1_q[colCnt_q];
    newCol[2] = in_data;
    if (t) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
        win_d[i][2] = newCol[i];
      end
      tOut_d = (rowCnt_q >= RW'(2)) && (colCnt_q >= CW'(2));
      if (colLast) begin
        colCnt_d = '0;
        rowCnt_d = rowLast ? '0 : rowCnt_q + RW'(1);
      end else begin
        colCnt_d = colCnt_q + CW'(1);
      end
    end
  end

  // Position counters, window registers and the valid pulse. A reset always
  // wins over a coincident pixel, which drops that pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      colCnt_q <= '0;
      rowCnt_q <= '0;
      tOut_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      colCnt_q <= colCnt_d;
      rowCnt_q <= rowCnt_d;
      tOut_q   <= tOut_d;
      win_q    <= win_d;
    end
  end

  // Line buffers are plain storage with no reset. Stale contents after reset
  // or from a previous frame only ever reach windows that t_out masks. Each
  // accepted pixel ages one column: the old row r-1 moves to lb0, and the
  // new pixel becomes row r-1 for the next row.
  always_ff @(posedge clk) begin
    if (t && !rst) begin
      lb0_q[colCnt_q] <= lb1_q[colCnt_q];
      lb1_q[colCnt_q] <= in_data;
    end
  end

  assign win_data = win_q;
  assign t_out    = tOut_q;

`ifdef LINEBUF_FRAME_DONE_EN
  logic frameDone_q, frameDone_d;

  // The end of a frame is the last column of the last row. The pulse is
  // registered, so it lines up with the final t_out of the frame.
  always_comb begin
    frameDone_d = t && colLast && rowLast;
  end

  // End-of-frame pulse register. A reset on the last pixel suppresses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= frameDone_d;
    end
  end

  assign frame_done = frameDone_q;
`endif

endmodule

// File: doc/window_3x3_linebuf.md
Name: window_3x3_linebuf

Overview:
Streaming 3x3 sliding-window generator for raster-order pixel streams. It sits directly upstream of the 3x3 weighted-average/convolution stages. It accepts one pixel per cycle when t is high, buffers the two previous image rows internally, and presents a registered 3x3 window plus a one-cycle valid pulse (t_out). The window array layout matches the downstream [row][col] window input.

Parameters:
ELEMENT_WIDTH, 32, bit width of one pixel.
IMG_WIDTH, 16, pixels per row; must be >= 3.
IMG_HEIGHT, 16, rows per frame; must be >= 3.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
t  input  1  pixel-valid strobe; in_data is accepted on any cycle with t=1.
in_data  input  ELEMENT_WIDTH  pixel, raster order (row-major, column 0 first).
win_data  output  [2:0][2:0] x ELEMENT_WIDTH  unpacked window. [0][*] is the oldest row, [2][*] the newest; [*][0] is the leftmost column, [*][2] the newest.
t_out  output  1  one-cycle pulse: win_data holds a complete, in-image window.

Behaviour:
- Reset, applied synchronously when rst=1 at posedge:
  - col_cnt=0, row_cnt=0, t_out=0, all win_data=0.
  - Line-buffer RAM contents are not cleared; stale data is never exposed because of the t_out masking below.
- Storage:
  - Two line buffers, lb0 (row r-2) and lb1 (row r-1), each IMG_WIDTH x ELEMENT_WIDTH, indexed by col_cnt.
  - Counters are $clog2 sized.
- On a cycle with t=1, for pixel p at position (r=row_cnt, c=col_cnt):
  - New column vector: {lb0[c], lb1[c], p} maps to rows {0,1,2}.
  - Line-buffer update: lb0[c] <= lb1[c]; lb1[c] <= p. Read-before-write at the same address within the cycle.
  - Window shift for i=0..2: win[i][0] <= win[i][1]; win[i][1] <= win[i][2]; win[i][2] <= newcol[i].
  - t_out <= (r >= 2) && (c >= 2).
  - Column wrap: col_cnt increments; at IMG_WIDTH-1 it wraps to 0 and row_cnt increments.
  - Row wrap: at IMG_HEIGHT-1 with col wrap, row_cnt wraps to 0. The next pixel starts a new frame with no bubble.
- On a cycle with t=0:
  - All state holds; t_out <= 0.
  - Gaps of any length are allowed anywhere in the stream, including mid-row.
- Latency: the window containing pixel (r,c) is presented the cycle after that pixel is accepted, with t_out=1.
- Valid windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Boundary rules:
  - Windows straddling a row boundary (c<2) or using rows from the prior frame (r<2) may contain stale data. t_out=0 for these windows.
  - win_data is stable whenever t=0.
  - No backpressure: the consumer must accept each t_out pulse.
  - rst=1 together with t=1: reset wins and the pixel is dropped. The next accepted pixel is (0,0).
  - Reset mid-frame discards the partial frame.

Optional Feature:
LINEBUF_FRAME_DONE_EN
- Defined:
  - Adds output port frame_done (1 bit), reset value 0.
  - frame_done pulses high for one cycle, the cycle after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted. This is coincident with the final t_out.
  - If rst and the last pixel coincide, no pulse is generated.
- Undefined:
  - The port is absent; no extra logic.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=4, after rst: stream pixels v=4r+c (values 0..15) with t=1 continuously -> exactly 4 t_out pulses, on the cycles after v=10, 11, 14, 15. The first window is [[0,1,2],[4,5,6],[8,9,10]]; the last is [[5,6,7],[9,10,11],[13,14,15]].
2. Same stream with t=0 inserted for 3 cycles after every pixel -> identical window sequence. t_out pulses only the cycle after each of v=10, 11, 14, 15; win_data holds between pulses.
3. Two back-to-back frames (frame 2 values 100+4r+c) -> 8 pulses. The first window of frame 2 is [[100,101,102],[104,105,106],[108,109,110]], with no carry-over from frame 1.
4. rst asserted for 1 cycle after pixel v=9 of frame 1, then a fresh full frame -> t_out=0 immediately after reset. The next frame yields the same 4 windows as scenario 1.
5. rst=1 on the same cycle as t=1, in_data=55 -> the pixel is dropped; the next pixel is treated as (0,0). This is confirmed by the first window's top-left element being the next pixel's value.
6. With LINEBUF_FRAME_DONE_EN defined, scenario 3 -> frame_done pulses exactly twice, each coincident with the t_out for v=15 and v=115. frame_done is 0 at all other times, including after reset.
